// File: rtl/fault_resp_analyzer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fault_resp_analyzer : stuck-at fault response checker with detection
// bitmap, count and first-hit capture. Optional MISR via RESP_MISR_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fault_resp_analyzer #(
  parameter int PAT_W  = 3,
  parameter int RESP_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PAT_W-1:0]      in_pat,
  input  logic [RESP_W-1:0]     in_good,
  input  logic [RESP_W-1:0]     in_faulty,
  output logic [2**PAT_W-1:0]   det_map,
  output logic [PAT_W:0]        det_cnt,
  output logic [PAT_W-1:0]      first_det,
  output logic                  first_det_vld,
  output logic                  fault_detected,
  output logic                  busy,
`ifdef RESP_MISR_EN
  output logic [7:0]            misr_sig,
`endif
  output logic                  done
);

  localparam int             NUM_PAT = 2**PAT_W;
  localparam logic [PAT_W:0] c_NUM   = (PAT_W+1)'(NUM_PAT);
  localparam logic [PAT_W:0] c_LAST  = (PAT_W+1)'(NUM_PAT-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM_PAT-1:0]   r_det_map;
  logic [PAT_W:0]       r_det_cnt;
  logic [PAT_W-1:0]     r_first_det;
  logic                 r_first_vld;
  logic [PAT_W:0]       r_beat_cnt;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_done;

  logic w_accept;
  logic w_hit;
  logic w_new;
  logic w_last;

  // A start in COLLECT wins over a beat offered in the same cycle.
  assign w_accept = in_valid & r_in_ready & ~start;
  assign w_hit    = (in_good != in_faulty);
  assign w_new    = w_hit & ~r_det_map[in_pat];
  assign w_last   = (r_beat_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_det_map   <= '0;
      r_det_cnt   <= '0;
      r_first_det <= '0;
      r_first_vld <= 1'b0;
      r_beat_cnt  <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_COLLECT: begin
          if (start) begin
            r_state     <= S_COLLECT;
            r_det_map   <= '0;
            r_det_cnt   <= '0;
            r_first_det <= '0;
            r_first_vld <= 1'b0;
            r_beat_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_hit) begin
              r_det_map[in_pat] <= 1'b1;
              if (w_new && (r_det_cnt != c_NUM))
                r_det_cnt <= r_det_cnt + 1'b1;
              if (!r_first_vld) begin
                r_first_det <= in_pat;
                r_first_vld <= 1'b1;
              end
            end
            if (w_last) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESP_MISR_EN
  localparam int DW = 2*RESP_W;
  logic [DW+7:0] w_misr_ext;
  logic [7:0]    w_misr_in;
  logic [7:0]    r_misr;

  assign w_misr_ext = {8'd0, in_good, in_faulty};
  assign w_misr_in  = w_misr_ext[7:0];

  // Galois form of x^8+x^4+x^3+x^2+1 (feedback mask 0x1D).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_misr <= '0;
    else if (start)
      r_misr <= '0;
    else if (w_accept)
      r_misr <= {r_misr[6:0], 1'b0} ^ (r_misr[7] ? 8'h1D : 8'h00) ^ w_misr_in;
  end

  assign misr_sig = r_misr;
`endif

  assign in_ready       = r_in_ready;
  assign det_map        = r_det_map;
  assign det_cnt        = r_det_cnt;
  assign first_det      = r_first_det;
  assign first_det_vld  = r_first_vld;
  assign fault_detected = |r_det_map;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fault_resp_analyzer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fault_resp_analyzer : randomized self-checking bench with a list-based
// reference model of accepted beats. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fault_resp_analyzer;

  localparam int PAT_W   = 3;
  localparam int RESP_W  = 1;
  localparam int NUM_PAT = 2**PAT_W;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [PAT_W-1:0]    in_pat = '0;
  logic [RESP_W-1:0]   in_good = '0;
  logic [RESP_W-1:0]   in_faulty = '0;
  logic [NUM_PAT-1:0]  det_map;
  logic [PAT_W:0]      det_cnt;
  logic [PAT_W-1:0]    first_det;
  logic                first_det_vld;
  logic                fault_detected;
  logic                busy;
  logic                done;
`ifdef RESP_MISR_EN
  logic [7:0]          misr_sig;
`endif

  fault_resp_analyzer #(.PAT_W(PAT_W), .RESP_W(RESP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_pat(in_pat), .in_good(in_good),
    .in_faulty(in_faulty), .det_map(det_map), .det_cnt(det_cnt),
    .first_det(first_det), .first_det_vld(first_det_vld),
    .fault_detected(fault_detected), .busy(busy),
`ifdef RESP_MISR_EN
    .misr_sig(misr_sig),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit bp_en  = 1'b0;

  // Reference model: the list of beats accepted in the current run.
  int m_pat[$];
  bit m_hit[$];
  int m_state = 0;   // 0 idle, 1 collecting, 2 done

  function automatic logic [31:0] exp_pack();
    logic [NUM_PAT-1:0] map = '0;
    int cnt = 0;
    int first = 0;
    bit vld = 0;
    foreach (m_pat[i]) begin
      if (m_hit[i]) begin
        if (!vld) begin first = m_pat[i]; vld = 1; end
        map[m_pat[i]] = 1'b1;
      end
    end
    cnt = $countones(map);
    return 32'({map, 4'(cnt), 3'(first), vld, |map,
                m_state == 1, m_state == 2, m_state == 1});
  endfunction

  function automatic logic [31:0] act_pack();
    return 32'({det_map, det_cnt, first_det, first_det_vld, fault_detected,
                busy, done, in_ready});
  endfunction

  task automatic model_clear();
    m_pat.delete();
    m_hit.delete();
  endtask

  task automatic pulse_start(input bit with_beat);
    @(posedge clk); #1;
    start = 1'b1;
    if (with_beat) begin
      in_valid  = 1'b1;
      in_pat    = 3'd7;
      in_good   = 1'b0;
      in_faulty = 1'b1;
    end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    m_state = 1;
  endtask

  task automatic beat(input int p, input bit hit);
    int gap;
    logic g;
    gap = bp_en ? $urandom_range(0, 3) : 0;
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
    end
    g = 1'($urandom);
    in_valid  = 1'b1;
    in_pat    = 3'(p);
    in_good   = g;
    in_faulty = g ^ hit;
    if (m_state == 1) begin
      m_pat.push_back(p);
      m_hit.push_back(hit);
      if (m_pat.size() == NUM_PAT) m_state = 2;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    m_state = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (act_pack() !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", c, act_pack(), 32'd0);
      end
    end
  endtask

  task automatic test_full_run();
    pulse_start(1'b0);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL full_started got=%h want=%h", act_pack(), exp_pack());
    end
    for (int p = 0; p < NUM_PAT; p++) beat(p, (p == 3) || (p == 6));
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL full_result got=%h want=%h", act_pack(), exp_pack());
    end
    checks++;
    if ({det_map, det_cnt, first_det, first_det_vld, done} !== {8'h48, 4'd2, 3'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL full_const map=%h cnt=%0d first=%0d done=%b want map=48 cnt=2 first=3 done=1",
               det_map, det_cnt, first_det, done);
    end
  endtask

  task automatic test_no_detect();
    pulse_start(1'b0);
    for (int p = 0; p < NUM_PAT; p++) beat(p, 1'b0);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack() || fault_detected !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL no_detect got=%h want=%h", act_pack(), exp_pack());
    end
  endtask

  task automatic test_backpressure_dup();
    bp_en = 1'b1;
    pulse_start(1'b0);
    beat(5, 1'b1);
    beat(5, 1'b1);
    beat(2, 1'b1);
    for (int k = 0; k < 4; k++) beat($urandom_range(0, 7), 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_early_done done=%b busy=%b want done=0 busy=1", done, busy);
    end
    beat($urandom_range(0, 7), 1'b0);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL bp_dup got=%h want=%h", act_pack(), exp_pack());
    end
    checks++;
    if ({det_map, det_cnt, first_det} !== {8'h24, 4'd2, 3'd5}) begin
      errors++;
      $display("FAIL bp_const map=%h cnt=%0d first=%0d want map=24 cnt=2 first=5",
               det_map, det_cnt, first_det);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_restart();
    pulse_start(1'b0);
    beat(1, 1'b1);
    beat(4, 1'b0);
    beat(6, 1'b1);
    beat(0, 1'b0);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL restart_mid got=%h want=%h", act_pack(), exp_pack());
    end
    pulse_start(1'b1);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL restart_clear got=%h want=%h", act_pack(), exp_pack());
    end
    for (int p = 0; p < NUM_PAT - 1; p++) beat(7 - p, p == 2);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack() || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_seven got=%h want=%h", act_pack(), exp_pack());
    end
    beat(0, 1'b0);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack() || done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done got=%h want=%h", act_pack(), exp_pack());
    end
  endtask

  task automatic test_abort();
    pulse_start(1'b0);
    beat(2, 1'b1);
    beat(3, 1'b1);
    beat(4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    m_state = 0;
    checks++;
    if (act_pack() !== 32'd0) begin
      errors++;
      $display("FAIL abort_async got=%h want=%h", act_pack(), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL abort_idle got=%h want=%h", act_pack(), exp_pack());
    end
  endtask

  task automatic test_random();
    bp_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      pulse_start(1'b0);
      for (int b = 0; b < NUM_PAT; b++) begin
        beat($urandom_range(0, 7), ($urandom_range(0, 3) == 0));
        @(negedge clk);
        checks++;
        if (act_pack() !== exp_pack()) begin
          errors++;
          $display("FAIL random run=%0d beat=%0d got=%h want=%h", r, b, act_pack(), exp_pack());
        end
      end
    end
    // Beats offered in DONE must be ignored.
    beat(1, 1'b1);
    @(negedge clk);
    checks++;
    if (act_pack() !== exp_pack()) begin
      errors++;
      $display("FAIL done_ignore got=%h want=%h", act_pack(), exp_pack());
    end
    bp_en = 1'b0;
  endtask

`ifdef RESP_MISR_EN
  task automatic misr_run(input bit flip, output logic [7:0] sig);
    pulse_start(1'b0);
    for (int p = 0; p < NUM_PAT; p++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_pat    = 3'(p);
      in_good   = 1'(p);
      in_faulty = 1'(p) ^ ((p == 3) || (p == 6)) ^ (flip && p == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    sig = misr_sig;
  endtask

  task automatic test_misr();
    logic [7:0] s1, s2, s3;
    misr_run(1'b0, s1);
    misr_run(1'b0, s2);
    misr_run(1'b1, s3);
    checks++;
    if (s1 !== s2 || s1 === 8'h00) begin
      errors++;
      $display("FAIL misr_repeat got=%h,%h want equal nonzero", s1, s2);
    end
    checks++;
    if (s3 === s1) begin
      errors++;
      $display("FAIL misr_flip got=%h want different from %h", s3, s1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_no_detect();
    test_backpressure_dup();
    test_restart();
    test_abort();
    test_random();
`ifdef RESP_MISR_EN
    test_misr();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
